// File: rtl/core_pkg.sv
// Shared types for the instruction fetch path: FSM states and the buffered
// {pc, instr} entry handed to decode.
package core_pkg;

   localparam int ILEN = 32;
   localparam int PC_W = 32;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush beats both push and pop.
module fetch_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  fetch_entry_t     data_i,
   output fetch_entry_t     data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rptr_q];

   // A push into a full FIFO is allowed when the head leaves in the same cycle.
   assign push_ok_s = push_i & (~full_o | pop_i);
   assign pop_ok_s  = pop_i & ~empty_o;

   // Next pointer and occupancy.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok_s) begin
            wptr_d = wptr_q + PTR_W'(1'b1);
         end else begin
            wptr_d = wptr_q;
         end
         if (pop_ok_s) begin
            rptr_d = rptr_q + PTR_W'(1'b1);
         end else begin
            rptr_d = rptr_q;
         end
         count_d = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
      end
   end

   // Pointer, occupancy and storage registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         if (push_ok_s && !flush_i) begin
            mem_q[wptr_q] <= data_i;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one word request at a time
// and buffers responses for decode; a branch redirect flushes and restarts.
module fetch_unit
   import core_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            branch_taken_i,
   input  logic [XLEN-1:0] pc_branch_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   output logic            instr_valid_o,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] pc_o,
   input  logic            instr_ready_i
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;

   logic             issue_s;
   logic             push_s;
   logic             pop_s;
   logic             full_s;
   logic             empty_s;
   logic [CNT_W-1:0] count_s;
   fetch_entry_t     push_entry_s;
   fetch_entry_t     head_s;

   // The full check uses registered occupancy, so a pop this cycle does not
   // unblock a request until the next cycle.
   assign imem_req_o  = rst_ni & (state_q == RUN) & ~full_s & ~branch_taken_i;
   assign imem_addr_o = word_align(fetch_pc_q);
   assign issue_s     = imem_req_o & imem_gnt_i;

   assign push_s       = (state_q == WAIT) & imem_rvalid_i & ~branch_taken_i;
   assign pop_s        = ~empty_s & instr_ready_i;
   assign push_entry_s = '{pc: req_pc_q, instr: imem_rdata_i};

   assign instr_valid_o = ~empty_s;
   assign instr_o       = head_s.instr;
   assign pc_o          = head_s.pc;

   // Next fetch PC, captured request PC and FSM state.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      state_d    = state_q;
      if (branch_taken_i) begin
         fetch_pc_d = pc_branch_i;
      end else if (issue_s) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
         req_pc_d   = fetch_pc_q;
      end else begin
         fetch_pc_d = fetch_pc_q;
      end
      case (state_q)
         RUN: begin
            if (issue_s) begin
               state_d = WAIT;
            end else begin
               state_d = RUN;
            end
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               state_d = RUN;
            end else if (branch_taken_i) begin
               state_d = DROP;
            end else begin
               state_d = WAIT;
            end
         end
         DROP: begin
            if (imem_rvalid_i) begin
               state_d = RUN;
            end else begin
               state_d = DROP;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // FSM and PC registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (branch_taken_i),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .data_i  (push_entry_s),
      .data_o  (head_s),
      .count_o (count_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   logic unused_s;
   assign unused_s = ^count_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table plus randomized run against a queue-based fetch model.
module tb_fetch_unit;

   logic        clk;
   logic        rst_ni;
   logic        branch_taken;
   logic [31:0] pc_branch;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_ready;

   int n_cmp = 0;
   int n_fail = 0;

   fetch_unit #(
      .XLEN       (32),
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .branch_taken_i (branch_taken),
      .pc_branch_i    (pc_branch),
      .imem_req_o     (imem_req),
      .imem_addr_o    (imem_addr),
      .imem_gnt_i     (imem_gnt),
      .imem_rvalid_i  (imem_rvalid),
      .imem_rdata_i   (imem_rdata),
      .instr_valid_o  (instr_valid),
      .instr_o        (instr),
      .pc_o           (pc),
      .instr_ready_i  (instr_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        br;
      logic [31:0] tgt;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   vec_t vecs[$];

   function automatic logic [31:0] memw(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1F00;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic br, input logic [31:0] tgt, input logic gnt, input logic rv,
                      input logic [31:0] rdata, input logic rdy, input logic e_req,
                      input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_pc,
                      input logic [31:0] e_instr);
      vec_t v;
      v.br = br; v.tgt = tgt; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic br, input logic [31:0] tgt, input logic gnt, input logic rv,
                        input logic [31:0] rdata, input logic rdy);
      branch_taken = br;
      pc_branch    = tgt;
      imem_gnt     = gnt;
      imem_rvalid  = rv;
      imem_rdata   = rdata;
      instr_ready  = rdy;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
      chk({tag, "_addr"}, imem_addr, 32'h0000_0000);
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, "_instr"}, instr, 32'd0);
      chk({tag, "_pc"}, pc, 32'd0);
   endtask

   // Reference model state
   logic        m_out;
   logic        m_stale;
   logic [31:0] m_pc;
   logic [31:0] m_rpc;
   ent_t        m_q[$];

   initial begin
      drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
      rst_ni = 1'b0;

      // Directed table from reset release
      add(0, 32'h0,         1, 0, 32'h0,          1, 1, 32'h0,         0, 0, 0);
      add(0, 32'h0,         1, 1, memw(32'h0),    1, 0, 32'h4,         0, 0, 0);
      add(0, 32'h0,         1, 0, 32'h0,          1, 1, 32'h4,         1, 32'h0, memw(32'h0));
      add(0, 32'h0,         1, 1, memw(32'h4),    0, 0, 32'h8,         0, 0, 0);
      add(0, 32'h0,         0, 0, 32'h0,          0, 1, 32'h8,         1, 32'h4, memw(32'h4));
      add(0, 32'h0,         0, 0, 32'h0,          0, 1, 32'h8,         1, 32'h4, memw(32'h4));
      add(0, 32'h0,         1, 0, 32'h0,          0, 1, 32'h8,         1, 32'h4, memw(32'h4));
      add(0, 32'h0,         1, 1, memw(32'h8),    0, 0, 32'hC,         1, 32'h4, memw(32'h4));
      add(0, 32'h0,         1, 0, 32'h0,          0, 0, 32'hC,         1, 32'h4, memw(32'h4));
      add(0, 32'h0,         1, 0, 32'h0,          1, 0, 32'hC,         1, 32'h4, memw(32'h4));
      add(0, 32'h0,         1, 0, 32'h0,          0, 1, 32'hC,         1, 32'h8, memw(32'h8));
      add(1, 32'h100,       1, 0, 32'h0,          0, 0, 32'h10,        1, 32'h8, memw(32'h8));
      add(0, 32'h0,         1, 0, 32'h0,          0, 0, 32'h100,       0, 0, 0);
      add(0, 32'h0,         1, 1, 32'hDEAD_BEEF,  0, 0, 32'h100,       0, 0, 0);
      add(0, 32'h0,         1, 0, 32'h0,          1, 1, 32'h100,       0, 0, 0);
      add(0, 32'h0,         1, 1, memw(32'h100),  1, 0, 32'h104,       0, 0, 0);
      add(1, 32'hFFFF_FFFC, 1, 0, 32'h0,          1, 0, 32'h104,       1, 32'h100, memw(32'h100));
      add(0, 32'h0,         1, 0, 32'h0,          0, 1, 32'hFFFF_FFFC, 0, 0, 0);
      add(0, 32'h0,         1, 1, memw(32'hFFFF_FFFC), 0, 0, 32'h0,    0, 0, 0);
      add(0, 32'h0,         1, 0, 32'h0,          0, 1, 32'h0,         1, 32'hFFFF_FFFC, memw(32'hFFFF_FFFC));
      add(1, 32'h200,       1, 1, memw(32'h0),    1, 0, 32'h4,         1, 32'hFFFF_FFFC, memw(32'hFFFF_FFFC));
      add(0, 32'h0,         0, 1, 32'h1234_5678,  1, 1, 32'h200,       0, 0, 0);
      add(0, 32'h0,         1, 0, 32'h0,          1, 1, 32'h200,       0, 0, 0);
      add(0, 32'h0,         0, 0, 32'h0,          1, 0, 32'h204,       0, 0, 0);

      repeat (2) @(negedge clk);
      #1;
      chk_reset_outputs("rst");
      @(negedge clk);
      rst_ni = 1'b1;
      #1;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].br, vecs[i].tgt, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdy);
         #1;
         chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
         chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
         chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
         if (vecs[i].e_valid) begin
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
         end
      end

      // Asynchronous reset while a response is outstanding
      @(negedge clk);
      drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
      #2;
      rst_ni = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      @(negedge clk);
      rst_ni = 1'b1;

      // Randomized run against the model
      m_out = 1'b0; m_stale = 1'b0; m_pc = 32'h0; m_rpc = 32'h0;
      m_q.delete();
      for (int c = 0; c < 3000; c++) begin
         logic        br, gnt, rv, rdy, e_req, pop;
         logic [31:0] tgt, rd;
         ent_t        e;
         @(negedge clk);
         br  = ($urandom % 10) == 0;
         tgt = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         gnt = ($urandom % 3) != 0;
         rv  = m_out ? (($urandom % 2) == 0) : (($urandom % 5) == 0);
         rd  = m_out ? memw(m_rpc) : $urandom;
         rdy = ($urandom % 3) != 0;
         drive(br, tgt, gnt, rv, rd, rdy);
         e_req = !m_out && (m_q.size() < 2) && !br;
         #1;
         chk("rnd_req", {31'd0, imem_req}, {31'd0, e_req});
         chk("rnd_addr", imem_addr, m_pc);
         chk("rnd_valid", {31'd0, instr_valid}, {31'd0, (m_q.size() > 0)});
         if (m_q.size() > 0) begin
            chk("rnd_pc", pc, m_q[0].pc);
            chk("rnd_instr", instr, m_q[0].instr);
         end
         pop = (m_q.size() > 0) && rdy;
         if (br) begin
            m_q.delete();
            m_pc = tgt;
            if (m_out) begin
               if (rv) begin
                  m_out = 1'b0;
                  m_stale = 1'b0;
               end else begin
                  m_stale = 1'b1;
               end
            end
         end else begin
            if (pop) void'(m_q.pop_front());
            if (m_out && rv) begin
               if (!m_stale) begin
                  e.pc = m_rpc;
                  e.instr = rd;
                  m_q.push_back(e);
               end
               m_out = 1'b0;
               m_stale = 1'b0;
            end
            if (e_req && gnt) begin
               m_rpc = m_pc;
               m_pc = m_pc + 32'd4;
               m_out = 1'b1;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
